// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
// Flag vectors are ordered {Z,C,N,O}.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_RESPOND
    } state_e;

    typedef enum logic [2:0] {
        COND_ALWAYS = 3'b000,
        COND_Z      = 3'b001,
        COND_NZ     = 3'b010,
        COND_C      = 3'b011,
        COND_NC     = 3'b100,
        COND_N      = 3'b101,
        COND_NN     = 3'b110,
        COND_O      = 3'b111
    } cond_e;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_O = 0;

    localparam logic [4:0] FUN_ADD = 5'b10100;
    localparam logic [4:0] FUN_ADC = 5'b10101;

endpackage

// File: rtl/alu_command_sequencer_if.sv
// Request, ALU drive and response bundle of the command sequencer.
// slave is the sequencer side, master the requester/ALU side.
interface alu_command_sequencer_if;

    logic        ReqValid;
    logic        ReqReady;
    logic [31:0] ReqA;
    logic [31:0] ReqB;
    logic [4:0]  ReqFunSel;
    logic        ReqWF;
    logic [2:0]  ReqCond;

    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  FunSel;
    logic        WF;
    logic [31:0] ALUOut;
    logic [3:0]  FlagsOut;

    logic        RspValid;
    logic        RspReady;
    logic [31:0] RspResult;
    logic [3:0]  RspFlags;
    logic        RspSkipped;
    logic [15:0] OpCount;

    modport slave (
        input  ReqValid, ReqA, ReqB, ReqFunSel, ReqWF, ReqCond,
        input  ALUOut, FlagsOut, RspReady,
        output ReqReady, A, B, FunSel, WF,
        output RspValid, RspResult, RspFlags, RspSkipped, OpCount
    );

    modport master (
        output ReqValid, ReqA, ReqB, ReqFunSel, ReqWF, ReqCond,
        output ALUOut, FlagsOut, RspReady,
        input  ReqReady, A, B, FunSel, WF,
        input  RspValid, RspResult, RspFlags, RspSkipped, OpCount
    );

endinterface

// File: rtl/alu_cond_eval.sv
// Combinational check of a request condition code against ALU flags.
module alu_cond_eval
    import alu_seq_pkg::*;
(
    input  logic [2:0] Cond,
    input  logic [3:0] Flags,
    output logic       Pass
);

    always_comb begin
        Pass = 1'b0;
        unique case (cond_e'(Cond))
            COND_ALWAYS: Pass = 1'b1;
            COND_Z:      Pass = Flags[FLAG_Z];
            COND_NZ:     Pass = ~Flags[FLAG_Z];
            COND_C:      Pass = Flags[FLAG_C];
            COND_NC:     Pass = ~Flags[FLAG_C];
            COND_N:      Pass = Flags[FLAG_N];
            COND_NN:     Pass = ~Flags[FLAG_N];
            COND_O:      Pass = Flags[FLAG_O];
        endcase
    end

endmodule

// File: rtl/alu_command_sequencer.sv
// Sequences one conditional ALU command at a time: accept, issue,
// capture the ALU result, then hold the response until taken.
module alu_command_sequencer
    import alu_seq_pkg::*;
(
    input logic                    Clock,
    input logic                    Reset,
    alu_command_sequencer_if.slave bus
);

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [4:0]  fun_q, fun_d;
    logic        wf_q, wf_d;
    logic [31:0] res_q, res_d;
    logic [3:0]  flg_q, flg_d;
    logic        skip_q, skip_d;
    logic [15:0] cnt_q, cnt_d;
    logic        pass;
    logic        accept;

    alu_cond_eval u_cond (
        .Cond  (bus.ReqCond),
        .Flags (bus.FlagsOut),
        .Pass  (pass)
    );

    assign bus.ReqReady = (state_q == ST_IDLE) & ~Reset;
    assign accept       = bus.ReqValid & bus.ReqReady;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        fun_d   = fun_q;
        wf_d    = wf_q;
        res_d   = res_q;
        flg_d   = flg_q;
        skip_d  = skip_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d   = bus.ReqA;
                    b_d   = bus.ReqB;
                    fun_d = bus.ReqFunSel;
                    wf_d  = bus.ReqWF;
                    if (pass) begin
                        state_d = ST_ISSUE;
                    end else begin
                        // Skipped requests report the flags seen at accept
                        state_d = ST_RESPOND;
                        res_d   = '0;
                        flg_d   = bus.FlagsOut;
                        skip_d  = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                res_d   = bus.ALUOut;
                flg_d   = bus.FlagsOut;
                skip_d  = 1'b0;
                cnt_d   = cnt_q + 16'd1;
                state_d = ST_RESPOND;
            end
            ST_RESPOND: begin
                if (bus.RspReady) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            fun_q   <= '0;
            wf_q    <= 1'b0;
            res_q   <= '0;
            flg_q   <= '0;
            skip_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fun_q   <= fun_d;
            wf_q    <= wf_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            skip_q  <= skip_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.A          = a_q;
    assign bus.B          = b_q;
    assign bus.FunSel     = fun_q;
    assign bus.WF         = (state_q == ST_ISSUE) & wf_q;
    assign bus.RspValid   = (state_q == ST_RESPOND);
    assign bus.RspResult  = res_q;
    assign bus.RspFlags   = flg_q;
    assign bus.RspSkipped = skip_q;
    assign bus.OpCount    = cnt_q;

endmodule
